// File: rtl/ravan_pkg.sv
// Shared widths, FSM state encoding and key-slice helper for the RAVAN decryption scheduler.
package ravan_pkg;

    localparam int unsigned DW     = 64;
    localparam int unsigned SLICES = 8;
    localparam int unsigned KW     = DW * SLICES;
    localparam int unsigned SLW    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [DW-1:0] key_slice(input logic [KW-1:0] key, input logic [SLW-1:0] i);
        return key[int'(i) * DW +: DW];
    endfunction

endpackage

// File: rtl/ravan_dec_step.sv
// One RAVAN decryption slice-step: y = ~(t - r) ^ k, modulo 2^64.
module ravan_dec_step
    import ravan_pkg::*;
(
    input  logic [DW-1:0] t,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] k,
    output logic [DW-1:0] y_c
);

    assign y_c = (~(t - r)) ^ k;

endmodule

// File: rtl/ravan_dec_scheduler.sv
// Two-requester round-robin scheduler driving an iterative RAVAN decryption engine.
// Optional abort input enabled by defining RAVAN_SCHED_ABORT_EN.
module ravan_dec_scheduler
    import ravan_pkg::*;
#(
    parameter int unsigned ROUNDS = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    input  logic [DW-1:0] req_real0,
    input  logic [DW-1:0] req_real1,
    input  logic [KW-1:0] req_key0,
    input  logic [KW-1:0] req_key1,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_id,
    output logic          busy
`ifdef RAVAN_SCHED_ABORT_EN
    ,
    input  logic          abort
`endif
);

    localparam int unsigned     RW         = 6;
    localparam logic [RW-1:0]   LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [SLW-1:0]  TOP_SLICE  = SLW'(SLICES - 1);
    localparam logic [1:0]      ST_IDLE    = IDLE;
    localparam logic [1:0]      ST_RUN     = RUN;
    localparam logic [1:0]      ST_DONE    = DONE;

    logic [1:0]     state_q;
    logic [1:0]     state_d;
    logic           last_q;
    logic           id_q;
    logic [DW-1:0]  temp_q;
    logic [DW-1:0]  real_q;
    logic [KW-1:0]  key_q;
    logic [RW-1:0]  round_q;
    logic [SLW-1:0] slice_q;

    logic           grant;
    logic           accept;
    logic           last_step;
    logic           abort_run;
    logic [DW-1:0]  step_y;

    ravan_dec_step u_step (
        .t   (temp_q),
        .r   (real_q),
        .k   (key_slice(key_q, slice_q)),
        .y_c (step_y)
    );

`ifdef RAVAN_SCHED_ABORT_EN
    assign abort_run = abort && (state_q == ST_RUN);
`else
    assign abort_run = 1'b0;
`endif

    // Both valid: the requester not served last wins; otherwise the lone valid one.
    assign grant     = (&req_valid) ? ~last_q : req_valid[1];
    assign req_ready = (state_q == ST_IDLE && !rst && |req_valid) ? {grant, ~grant} : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign last_step = (round_q == LAST_ROUND) && (slice_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN: begin
                if (abort_run)      state_d = ST_IDLE;
                else if (last_step) state_d = ST_DONE;
            end
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            temp_q    <= '0;
            real_q    <= '0;
            key_q     <= '0;
            round_q   <= '0;
            slice_q   <= TOP_SLICE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= (state_d == ST_DONE);
            busy      <= (state_d != ST_IDLE);
            if (accept) begin
                temp_q  <= grant ? req_data1 : req_data0;
                real_q  <= grant ? req_real1 : req_real0;
                key_q   <= grant ? req_key1  : req_key0;
                id_q    <= grant;
                last_q  <= grant;
                round_q <= '0;
                slice_q <= TOP_SLICE;
            end
            // Slices walk 7..0 within a round; the final step also publishes the result.
            if (state_q == ST_RUN && !abort_run) begin
                temp_q <= step_y;
                if (slice_q == '0) begin
                    slice_q <= TOP_SLICE;
                    round_q <= round_q + RW'(1);
                end else begin
                    slice_q <= slice_q - SLW'(1);
                end
                if (last_step) begin
                    rsp_data <= step_y;
                    rsp_id   <= id_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ravan_dec_scheduler.sv
// Self-checking bench for ravan_dec_scheduler: per-cycle job-level model plus directed scenarios.
module tb_ravan_dec_scheduler;

    localparam int unsigned ROUNDS = 21;
    localparam int unsigned STEPS  = 8 * ROUNDS;

    localparam logic [63:0]  D_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0]  R_A = 64'h1111_2222_3333_4444;
    localparam logic [511:0] K_A = {64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0,
                                    64'hDEAD_BEEF_0BAD_F00D, 64'h0000_0000_FFFF_FFFF,
                                    64'h1357_9BDF_2468_ACE0, 64'hFEDC_BA98_7654_3210,
                                    64'h5555_AAAA_5555_AAAA, 64'h0000_0000_0000_0001};
    localparam logic [63:0]  D_B = 64'hCAFE_F00D_1234_0000;
    localparam logic [63:0]  R_B = 64'h0000_0000_0000_0007;
    localparam logic [511:0] K_B = {8{64'h0123_0000_4567_89AB}};
    localparam logic [63:0]  D_C = 64'h8000_0000_0000_0001;
    localparam logic [63:0]  R_C = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [511:0] K_C = {K_B[255:0], K_A[511:256]};

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [63:0]  req_data0, req_data1, req_real0, req_real1;
    logic [511:0] req_key0, req_key1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_data;
    logic         rsp_id;
    logic         busy;
    logic         abort;

    ravan_dec_scheduler #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_real0 (req_real0),
        .req_real1 (req_real1),
        .req_key0  (req_key0),
        .req_key1  (req_key1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef RAVAN_SCHED_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Full decryption of one job: ROUNDS passes over key slices 7 down to 0.
    function automatic logic [63:0] ref_decrypt(input logic [63:0] d, input logic [63:0] r,
                                                input logic [511:0] k);
        logic [63:0] t;
        t = d;
        for (int rd = 0; rd < int'(ROUNDS); rd++)
            for (int s = 7; s >= 0; s--)
                t = (~(t - r)) ^ k[64*s +: 64];
        return t;
    endfunction

    // Job-level model: in-flight flag, remaining steps, pending result, round-robin pointer.
    bit          m_valid = 0;
    bit          m_busy, m_have;
    int          m_left;
    logic        m_last, m_pend_id, m_rsp_id;
    logic [63:0] m_pend, m_rsp_data;
    int          acc_cyc[$];
    logic        acc_id[$];
    logic        rsp_ids[$];

    always @(negedge clk) begin
        logic       g;
        logic [1:0] exp_rr;
        if (m_valid) begin
            if (rst || m_busy || req_valid == 2'b00) exp_rr = 2'b00;
            else if (req_valid == 2'b11)             exp_rr = m_last ? 2'b01 : 2'b10;
            else                                     exp_rr = req_valid;
            chk("req_ready", 64'(req_ready), 64'(exp_rr));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_have));
            chk("rsp_data", rsp_data, m_rsp_data);
            chk("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
        end
        if (rst) begin
            m_valid    = 1;
            m_busy     = 0;
            m_have     = 0;
            m_last     = 1'b1;
            m_rsp_data = '0;
            m_rsp_id   = 1'b0;
        end else if (m_valid) begin
            if (!m_busy && req_valid != 2'b00) begin
                g         = (req_valid == 2'b11) ? ~m_last : req_valid[1];
                m_busy    = 1;
                m_left    = STEPS;
                m_pend    = g ? ref_decrypt(req_data1, req_real1, req_key1)
                              : ref_decrypt(req_data0, req_real0, req_key0);
                m_pend_id = g;
                m_last    = g;
                acc_cyc.push_back(cyc);
                acc_id.push_back(g);
            end else if (m_busy && !m_have) begin
                if (abort) begin
                    m_busy = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_have     = 1;
                        m_rsp_data = m_pend;
                        m_rsp_id   = m_pend_id;
                    end
                end
            end else if (m_have && rsp_ready) begin
                m_have = 0;
                m_busy = 0;
                rsp_ids.push_back(m_rsp_id);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string name, output int n);
        n = 0;
        while (!rsp_valid && n < 1000) begin
            tick();
            n++;
        end
        if (!rsp_valid) begin
            n_checks++;
            $display("FAIL %s: rsp_valid never rose within %0d cycles", name, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || rsp_valid) && n < 1000) begin
            tick();
            n++;
        end
        if (busy || rsp_valid) begin
            n_checks++;
            $display("FAIL %s: scheduler not idle after %0d cycles", name, n);
        end
    endtask

    task automatic set_job(input bit which, input logic [63:0] d, input logic [63:0] r,
                           input logic [511:0] k);
        if (which) begin
            req_data1 = d; req_real1 = r; req_key1 = k;
        end else begin
            req_data0 = d; req_real0 = r; req_key0 = k;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        abort     = 1'b0;
        set_job(0, '0, '0, '0);
        set_job(1, '0, '0, '0);

        chk("pin_zero", ref_decrypt(64'h0, 64'h0, '0), 64'h0);
        chk("pin_ident", ref_decrypt(64'h1234_5678_9ABC_DEF0, 64'h0, {512{1'b1}}),
            64'h1234_5678_9ABC_DEF0);
        chk("pin_even_cpl", ref_decrypt(64'hA5A5_0F0F_3C3C_9696, 64'h0, '0),
            64'hA5A5_0F0F_3C3C_9696);

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_data", rsp_data, 64'h0);

        // All-zero job from requester 0
        set_job(0, 64'h0, 64'h0, '0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_rsp("t1", n);
        chk("t1_latency", 64'(n), 64'd168);
        chk("t1_data", rsp_data, 64'h0);
        chk("t1_id", 64'(rsp_id), 64'h0);
        tick();
        wait_idle("t1");

        // All-ones key makes every step the identity
        set_job(1, 64'h1234_5678_9ABC_DEF0, 64'h0, {512{1'b1}});
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        wait_rsp("t2", n);
        chk("t2_data", rsp_data, 64'h1234_5678_9ABC_DEF0);
        chk("t2_id", 64'(rsp_id), 64'h1);
        tick();
        wait_idle("t2");

        // Both requesters held valid from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_job(0, D_A, R_A, K_A);
        set_job(1, D_B, R_B, K_B);
        acc_cyc.delete();
        acc_id.delete();
        rsp_ids.delete();
        req_valid = 2'b11;
        n = 0;
        while (acc_id.size() < 3 && n < 1000) begin
            tick();
            n++;
        end
        req_valid = 2'b00;
        n = 0;
        while (rsp_ids.size() < 3 && n < 1000) begin
            tick();
            n++;
        end
        if (acc_id.size() >= 3 && rsp_ids.size() >= 3) begin
            chk("rr_grant0", 64'(acc_id[0]), 64'h0);
            chk("rr_grant1", 64'(acc_id[1]), 64'h1);
            chk("rr_grant2", 64'(acc_id[2]), 64'h0);
            chk("rr_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd170);
            chk("rr_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd170);
            chk("rr_rsp0", 64'(rsp_ids[0]), 64'h0);
            chk("rr_rsp1", 64'(rsp_ids[1]), 64'h1);
            chk("rr_rsp2", 64'(rsp_ids[2]), 64'h0);
        end else begin
            n_checks++;
            $display("FAIL rr_count: accepts %0d responses %0d required 3", acc_id.size(), rsp_ids.size());
        end
        wait_idle("rr");

        // Response back-pressure with both requests pending
        rsp_ready = 1'b0;
        set_job(0, D_C, R_C, K_C);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        wait_rsp("bp", n);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_data", rsp_data, ref_decrypt(D_C, R_C, K_C));
            chk("bp_id", 64'(rsp_id), 64'h0);
            chk("bp_ready", 64'(req_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_ready", 64'(req_ready), 64'h2);
        tick();
        chk("bp_reaccept", 64'(busy), 64'h1);
        req_valid = 2'b00;
        wait_rsp("bp2", n);
        chk("bp2_id", 64'(rsp_id), 64'h1);
        tick();
        wait_idle("bp2");

        // Reset in the middle of a job
        set_job(0, D_A, R_A, K_A);
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        repeat (49) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", 64'(busy), 64'h0);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'h0);
        seen = 0;
        repeat (200) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("mr_no_rsp", 64'(seen), 64'h0);
        req_valid = 2'b11;
        #1;
        chk("mr_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        wait_rsp("mr", n);
        chk("mr_id", 64'(rsp_id), 64'h0);
        tick();
        wait_idle("mr");

`ifdef RAVAN_SCHED_ABORT_EN
        // Abort mid-run keeps the aborted requester as last served
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        repeat (19) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 64'(busy), 64'h0);
        seen = 0;
        repeat (200) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("ab_no_rsp", 64'(seen), 64'h0);
        req_valid = 2'b11;
        #1;
        chk("ab_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        wait_rsp("ab", n);
        chk("ab_id", 64'(rsp_id), 64'h0);
        tick();
        wait_idle("ab");
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ravan_dec_scheduler.md
# ravan_dec_scheduler

Two-requester scheduler for the RAVAN 64-bit decryption datapath. It arbitrates jobs round-robin, latches the winner's ciphertext, reference word and 512-bit key, then runs an iterative engine at one slice-step per clock. The engine covers ROUNDS rounds × 8 key slices. Results return on a valid/ready response channel tagged with the requester ID.

## Interface
- ROUNDS, 21: decryption rounds; range 1–63.
- DW, 64: data word width; fixed by the key-slice width.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester job valid
- req_ready  out  2  per-requester accept; at most one bit high
- req_data0 / req_data1  in  64  ciphertext word
- req_real0 / req_real1  in  64  reference (subtrahend) word
- req_key0 / req_key1  in  512  key; slice i = key[64*i +: 64]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  64  decrypted word
- rsp_id  out  1  requester that issued the job
- busy  out  1  high in RUN and DONE
- abort  in  1  present only with RAVAN_SCHED_ABORT_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - grant = round-robin over req_valid; pointer `last` holds the last granted ID (reset 1, so requester 0 wins first).
  - If both are valid, grant = ~last; if one is valid, grant = that one.
  - req_ready[grant] = 1 only in IDLE, only when some req_valid is high, never during rst.
- Accept (req_valid[g] & req_ready[g]):
  - temp ← req_data_g, real_r ← req_real_g, key_r ← req_key_g, id ← g, last ← g
  - round ← 0, slice ← 7; go to RUN.
- RUN, each clock:
  - temp ← (~(temp − real_r)) ^ key_r slice[slice], modulo 2^64.
  - slice decrements 7→0. At 0, slice wraps to 7 and round increments.
  - The step with round = ROUNDS−1 and slice = 0 is the last. Its edge loads rsp_data ← the step result and moves to DONE.
- DONE:
  - rsp_valid = 1; rsp_data and rsp_id hold stable.
  - On rsp_valid & rsp_ready, go to IDLE.
  - Input ports are ignored; no request is accepted in DONE or RUN.
- Reset: from any state, the next edge gives state IDLE, last = 1, temp/real_r/key_r/round = 0, slice = 7.
  - Resetting mid-RUN discards the job with no response.
- Outputs after reset: rsp_valid 0, rsp_data 0, rsp_id 0, busy 0, req_ready 0 during rst.

## Timing
- Accept edge E0. Step edges E1..E(8·ROUNDS). rsp_valid is high after edge E(8·ROUNDS): 168 cycles for ROUNDS = 21.
- Response handshake edge returns to IDLE. The earliest next accept is the following edge, so there is 1 IDLE cycle between jobs.
- Throughput with rsp_ready held high: one job per 8·ROUNDS+2 cycles.
- req_ready depends combinationally on req_valid and state only. There is no combinational path from req_* to rsp_*.
- When one requester was just served and both are valid, the other wins. A requester held valid alone is served back to back.

## Configuration
- RAVAN_SCHED_ABORT_EN defined:
  - The abort input exists. abort high in RUN forces IDLE on the next edge, with no response; last keeps the aborted ID.
  - abort is ignored in IDLE and DONE.
- Macro undefined: the abort port and logic are absent; jobs always complete.

## Structure
- Package ravan_pkg holds:
  - DW = 64 and SLICES = 8
  - the state enum {IDLE, RUN, DONE}
  - function key_slice(key, i)
- Sub-module ravan_dec_step computes ~(t − r) ^ k in one combinational stage.
- The scheduler owns the FSM, arbiter, counters and registers.

## Test plan
- Key 0, data 0, real 0, requester 0 → after 168 cycles rsp_data = 0, rsp_id = 0. The 168 steps alternate all-ones/zero.
- Key all ones, data 0x1234_5678_9ABC_DEF0, real 0 → rsp_data = 0x1234_5678_9ABC_DEF0, since each step is the identity.
- Both req_valid held from reset with distinct data:
  - grants alternate 0,1,0.
  - rsp_id sequence 0,1,0.
  - accepts 170 cycles apart.
- rsp_ready low for 10 cycles in DONE → rsp_valid, rsp_data and rsp_id stable, req_ready = 00. Then rsp_ready high → IDLE, and a new accept on the following edge.
- rst asserted at step 50 → next cycle busy 0, rsp_valid 0, no response ever issued. The next job with both valid goes to requester 0.
- With RAVAN_SCHED_ABORT_EN: abort at step 20 → IDLE next edge, no rsp_valid. With both valid afterwards, the grant goes to the other requester.
